// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word-addressed data RAM with a fixed multi-cycle
// access latency, upstream stall generation and branch resolution.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 7,
  parameter int PC_W    = 7,
  parameter int DST_W   = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              branch,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [PC_W-1:0]   pc_branch,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] data2,
  input  logic [DST_W-1:0]  dst,
  output logic              stall,
  output logic              pc_src,
  output logic [PC_W-1:0]   pc_branch_out,
  output logic              out_valid,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DST_W-1:0]  dst_out,
  output logic              misaligned
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [3:0]         count;
  logic [DATA_W-1:0]  ram [DEPTH];

  logic [ADDR_W-1:0]  word;
  logic               req;
  logic               aligned;
  logic               is_load;
  logic               done;

  // Upper address bits are dropped, so accesses wrap modulo DEPTH.
  assign word    = alu_result[ADDR_W+1:2];
  assign req     = in_valid & (mem_read | mem_write);
  assign aligned = (alu_result[1:0] == 2'b00);
  // A simultaneous read+write request behaves as a store.
  assign is_load = mem_read & ~mem_write;
  assign done    = (state == BUSY) && (count == 4'd0);

  assign stall         = (state == IDLE) ? (req & aligned) : (count != 4'd0);
  assign pc_src        = in_valid & branch & zero & (state == IDLE);
  assign pc_branch_out = pc_branch;

  // NOTE: the RAM array has no reset; clearing it would force it into flops
  // instead of a memory macro. A reset during BUSY clears state, so done never
  // fires and the pending store is dropped.
  always_ff @(posedge clk) begin
    if (done && mem_write) ram[word] <= data2;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 4'd0;
      out_valid      <= 1'b0;
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
      read_data      <= '0;
      alu_result_out <= '0;
      dst_out        <= '0;
      misaligned     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && aligned) begin
            state      <= BUSY;
            count      <= 4'(MEM_LAT - 1);
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
          end else begin
            out_valid      <= in_valid;
            mem_to_reg_out <= mem_to_reg;
            reg_write_out  <= reg_write & ~req;
            read_data      <= '0;
            alu_result_out <= alu_result;
            dst_out        <= dst;
            misaligned     <= req;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count      <= count - 4'd1;
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
          end else begin
            state          <= IDLE;
            out_valid      <= 1'b1;
            mem_to_reg_out <= mem_to_reg;
            reg_write_out  <= reg_write;
            read_data      <= is_load ? ram[word] : '0;
            alu_result_out <= alu_result;
            dst_out        <= dst;
            misaligned     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: the driver pushes expected WB results into a
// scoreboard queue and a negedge monitor pops and compares whenever out_valid is seen.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_to_reg, reg_write, branch, mem_write, mem_read, zero;
  logic [6:0]  pc_branch;
  logic [31:0] alu_result, data2, dst;
  logic        stall, pc_src, out_valid, mem_to_reg_out, reg_write_out, misaligned;
  logic [6:0]  pc_branch_out;
  logic [31:0] read_data, alu_result_out, dst_out;

  mem_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .branch(branch), .mem_write(mem_write), .mem_read(mem_read),
    .pc_branch(pc_branch), .zero(zero), .alu_result(alu_result), .data2(data2), .dst(dst),
    .stall(stall), .pc_src(pc_src), .pc_branch_out(pc_branch_out), .out_valid(out_valid),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .read_data(read_data),
    .alu_result_out(alu_result_out), .dst_out(dst_out), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] dst;
    logic        rw;
    logic        m2r;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every WB-side result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_valid_cycle", 32'(cyc), 32'(e.cyc));
          check("read_data", read_data, e.rd);
          check("alu_result_out", alu_result_out, e.alu);
          check("dst_out", dst_out, e.dst);
          check("reg_write_out", 32'(reg_write_out), 32'(e.rw));
          check("mem_to_reg_out", 32'(mem_to_reg_out), 32'(e.m2r));
          check("misaligned", 32'(misaligned), 32'(e.mis));
        end
      end else if (misaligned) begin
        check("misaligned_without_valid", 32'(misaligned), 32'd0);
      end
    end
  end

  task automatic clear_inputs();
    in_valid = 0; mem_to_reg = 0; reg_write = 0; branch = 0;
    mem_write = 0; mem_read = 0; zero = 0; pc_branch = '0;
    alu_result = '0; data2 = '0; dst = '0;
  endtask

  // Present one instruction just after a rising edge, hold it while stall is high,
  // and release it after the completing edge.
  task automatic issue(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic br, input logic z, input logic [31:0] alu,
                       input logic [31:0] d2, input logic [31:0] dd, input logic [6:0] pcb,
                       input logic [31:0] exp_rd, input logic exp_rw, input logic exp_mis,
                       input int exp_stall, input logic exp_pc_src, input string tag);
    exp_t e;
    int   n;
    in_valid = 1; mem_read = rd; mem_write = wr; mem_to_reg = m2r; reg_write = rw;
    branch = br; zero = z; alu_result = alu; data2 = d2; dst = dd; pc_branch = pcb;
    e.rd = exp_rd; e.alu = alu; e.dst = dd; e.rw = exp_rw; e.m2r = m2r; e.mis = exp_mis;
    e.cyc = cyc + exp_stall + 1;
    sb.push_back(e);
    #1;
    check({tag, "_pc_src"}, 32'(pc_src), 32'(exp_pc_src));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_alu_result_out", alu_result_out, 32'd0);
    check("rst_dst_out", dst_out, 32'd0);
    check("rst_flags", {28'd0, misaligned, reg_write_out, mem_to_reg_out, stall}, 32'd0);
    reset = 0;
    idle(1);

    // ALU op: one-edge latency, no stall.
    issue(0, 0, 0, 1, 0, 0, 32'h55, 32'h0, 32'd3, 7'h0, 32'h0, 1, 0, 0, 0, "alu");
    // Store then load to the same word, back to back.
    issue(0, 1, 0, 0, 0, 0, 32'h08, 32'h1234_5678, 32'd0, 7'h0, 32'h0, 0, 0, 2, 0, "st08");
    issue(1, 0, 1, 1, 0, 0, 32'h08, 32'h0, 32'd5, 7'h0, 32'h1234_5678, 1, 0, 2, 0, "ld08");
    // Misaligned load: no RAM access, reg_write suppressed.
    issue(1, 0, 1, 1, 0, 0, 32'h0A, 32'h0, 32'd6, 7'h0, 32'h0, 0, 1, 0, 0, "ld0a");
    // Address wrap: 0x200 maps to word 0.
    issue(0, 1, 0, 0, 0, 0, 32'h200, 32'hA5, 32'd0, 7'h0, 32'h0, 0, 0, 2, 0, "st200");
    issue(1, 0, 1, 1, 0, 0, 32'h000, 32'h0, 32'd7, 7'h0, 32'hA5, 1, 0, 2, 0, "ld000");
    // Branch taken / not taken.
    issue(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'd0, 7'h2C, 32'h0, 0, 0, 0, 1, "br_taken");
    issue(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'd0, 7'h2C, 32'h0, 0, 0, 0, 0, "br_not");
    branch = 1; zero = 1; pc_branch = 7'h2C; #1;
    check("pc_branch_out", 32'(pc_branch_out), 32'h2C);
    check("pc_src_no_valid", 32'(pc_src), 32'd0);
    clear_inputs();
    // Read+write together acts as a store.
    issue(1, 1, 0, 0, 0, 0, 32'h20, 32'h77, 32'd0, 7'h0, 32'h0, 0, 0, 2, 0, "rw20");
    issue(1, 0, 1, 1, 0, 0, 32'h20, 32'h0, 32'd8, 7'h0, 32'h77, 1, 0, 2, 0, "ld20");
    idle(2);

    // Reset during BUSY of a store must not commit it.
    issue(0, 1, 0, 0, 0, 0, 32'h10, 32'h1111_1111, 32'd0, 7'h0, 32'h0, 0, 0, 2, 0, "st10");
    in_valid = 1; mem_write = 1; alu_result = 32'h10; data2 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("busy_stall_before_reset", 32'(stall), 32'd1);
    reset = 1;
    clear_inputs();
    #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_read_data", read_data, 32'd0);
    @(negedge clk);
    reset = 0;
    idle(1);
    issue(1, 0, 1, 1, 0, 0, 32'h10, 32'h0, 32'd9, 7'h0, 32'h1111_1111, 1, 0, 2, 0, "ld10");

    idle(4);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
